// File: rtl/io_input_port.sv
// io_input_port: receiving end of the operator input interface.
//
// The raw push-button `valid` and switch bus `in` are each synchronised through
// two flops. The synchronised button is debounced, and every debounced 0->1 edge
// captures the synchronised switch value into a small circular FIFO. The CPU
// reads the FIFO through two word-addressed registers:
//   DATA   (ADDR_DATA): head entry, zero-extended; a read pops it (0 when empty)
//   STATUS (ADDR_STAT): {24'b0, count[3:0], 1'b0, ovf, full, ready}; a read clears ovf
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   valid      raw push-button, asynchronous to clk
//   in         raw switch bus, asynchronous to clk
//   cpu_re     CPU read strobe, one cycle per access
//   cpu_addr   CPU word address, qualified by cpu_re
//   cpu_rdata  registered read data, held until the next read
//   ready      FIFO non-empty
module io_input_port #(
  parameter int unsigned DATA_W     = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEB_CYCLES = 2,
  parameter logic [7:0]  ADDR_DATA  = 8'h00,
  parameter logic [7:0]  ADDR_STAT  = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] in,
  input  logic              cpu_re,
  input  logic [7:0]        cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic              ready
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  // Synchronisers
  logic              v_meta_q, v_s_q;
  logic [DATA_W-1:0] in_meta_q, in_s_q;

  // Debounce
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q;

  // FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  // Read port
  logic [31:0] rdata_q, rdata_d;

  logic push, pop, push_ok, overflow, full;
  logic rd_data, rd_stat;
  logic [31:0] status_word;

  assign ready     = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign cpu_rdata = rdata_q;

  assign push     = deb_q & ~deb_prev_q;
  assign rd_data  = cpu_re && (cpu_addr == ADDR_DATA);
  assign rd_stat  = cpu_re && (cpu_addr == ADDR_STAT);
  assign pop      = rd_data && ready;
  // A full FIFO still accepts a push when the same edge pops.
  assign push_ok  = push && (!full || pop);
  assign overflow = push && full && !pop;

  assign status_word = {24'b0, 4'(count_q), 1'b0, ovf_q, full, ready};

  // Debounce: deb follows v_s only after DEB_CYCLES consecutive differing cycles.
  always_comb begin
    deb_cnt_d = '0;
    deb_d     = deb_q;
    if (v_s_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = v_s_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  // Overflow set wins over the STATUS-read clear on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (rd_stat)  ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_data) begin
      rdata_d = ready ? 32'(mem[rd_ptr_q]) : 32'd0;
    end else if (rd_stat) begin
      rdata_d = status_word;
    end else if (cpu_re) begin
      rdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_meta_q   <= 1'b0;
      v_s_q      <= 1'b0;
      in_meta_q  <= '0;
      in_s_q     <= '0;
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      v_meta_q   <= valid;
      v_s_q      <= v_meta_q;
      in_meta_q  <= in;
      in_s_q     <= in_meta_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= in_s_q;
  end

endmodule
